// File: rtl/fault_monitor.sv
// Fault monitor downstream of the posit-adder checker: saturating statistics,
// a small FWFT FIFO of faulting results, and a sticky consecutive-fault alarm.
module fault_monitor #(
    parameter int FULL_NBITS   = 32,
    parameter int LOG_DEPTH    = 2,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_fault,
    input  logic                  in_mode,
    input  logic                  in_reverse_mode,
    input  logic [FULL_NBITS-1:0] in_true_sum,
    input  logic [FULL_NBITS-1:0] in_used_sum,
    input  logic [6:0]            in_true_scale,
    input  logic [6:0]            in_used_scale,
    input  logic                  clr_alarm,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [FULL_NBITS-1:0] rec_true_sum,
    output logic [FULL_NBITS-1:0] rec_used_sum,
    output logic [6:0]            rec_scale_diff,
    output logic [1:0]            rec_mode,
    output logic [CNT_W-1:0]      check_cnt,
    output logic [CNT_W-1:0]      fault_cnt,
    output logic [CNT_W-1:0]      trunc_cnt,
    output logic [CNT_W-1:0]      reverse_cnt,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  alarm
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int REC_W = 2 * FULL_NBITS + 9;

    typedef enum logic {MONITOR, ALARM} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             run_q, run_d;
    logic [CNT_W-1:0]       check_q, check_d, fault_q, fault_d;
    logic [CNT_W-1:0]       trunc_q, trunc_d, reverse_q, reverse_d, drop_q, drop_d;
    logic [LOG_DEPTH:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [REC_W-1:0]       mem_q [DEPTH];
    logic [REC_W-1:0]       mem_d [DEPTH];

    logic                   empty, full, pop, push_req, push, drop;
    logic [6:0]             scale_diff;
    logic [REC_W-1:0]       head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                     (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
        pop        = ~empty & rec_ready;
        push_req   = in_valid & in_fault;
        // A pop in the same cycle frees the slot the push needs.
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
        scale_diff = (in_true_scale >= in_used_scale) ? (in_true_scale - in_used_scale)
                                                      : (in_used_scale - in_true_scale);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[LOG_DEPTH-1:0]] = {in_true_sum, in_used_sum, scale_diff,
                                              in_reverse_mode, in_mode};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        check_d   = check_q;
        fault_d   = fault_q;
        trunc_d   = trunc_q;
        reverse_d = reverse_q;
        drop_d    = drop_q;
        if (in_valid) begin
            check_d = sat_inc(check_q);
            if (in_fault)        fault_d   = sat_inc(fault_q);
            if (in_mode)         trunc_d   = sat_inc(trunc_q);
            if (in_reverse_mode) reverse_d = sat_inc(reverse_q);
        end
        if (drop) begin
            drop_d = sat_inc(drop_q);
        end

        run_d = run_q;
        if (in_valid) begin
            run_d = in_fault ? ((&run_q) ? run_q : run_q + 8'd1) : 8'd0;
        end
        if (clr_alarm) begin
            run_d = 8'd0;
        end

        state_d = state_q;
        case (state_q)
            MONITOR: if (!clr_alarm && push_req && run_d >= 8'(ALARM_THRESH)) state_d = ALARM;
            ALARM:   if (clr_alarm) state_d = MONITOR;
            default: state_d = MONITOR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MONITOR;
            run_q     <= '0;
            check_q   <= '0;
            fault_q   <= '0;
            trunc_q   <= '0;
            reverse_q <= '0;
            drop_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            check_q   <= check_d;
            fault_q   <= fault_d;
            trunc_q   <= trunc_d;
            reverse_q <= reverse_d;
            drop_q    <= drop_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end

    // Record fields read as zero whenever nothing is presented.
    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
    end

    assign rec_valid      = ~empty;
    assign rec_true_sum   = head[REC_W-1 -: FULL_NBITS];
    assign rec_used_sum   = head[FULL_NBITS+8 -: FULL_NBITS];
    assign rec_scale_diff = head[8:2];
    assign rec_mode       = head[1:0];
    assign check_cnt      = check_q;
    assign fault_cnt      = fault_q;
    assign trunc_cnt      = trunc_q;
    assign reverse_cnt    = reverse_q;
    assign drop_cnt       = drop_q;
    assign alarm          = (state_q == ALARM);

endmodule
